// File: rtl/sseg_scan.sv
// rtl/sseg_scan.sv - four-digit display scan driver with debounced gear code
module sseg_scan #(
    parameter int CLK_DIV      = 100_000,
    parameter int STABLE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gear_in,
    output logic       ce,
    output logic [3:0] an_sel,
    output logic [6:0] char_sel,
    output logic [1:0] gear_q
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int STB_W = $clog2(STABLE_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_TICKS);
    localparam logic [STB_W-1:0] STB_ONE  = STB_W'(1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    logic [1:0]       gear_m;
    logic [1:0]       gear_s;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [1:0]       cand;
    logic [STB_W-1:0] stb_cnt;

    logic             slot_end;
    logic [3:0]       an_nxt;
    logic [6:0]       char_nxt;
    logic [1:0]       cand_nxt;
    logic [STB_W-1:0] stb_nxt;
    logic             accept;

    assign slot_end = (cnt == CNT_LAST);

    // Two-flop synchroniser for the possibly asynchronous gear request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gear_m <= 2'b00;
            gear_s <= 2'b00;
        end else begin
            gear_m <= gear_in;
            gear_s <= gear_m;
        end
    end

    // Prescaler: wraps every CLK_DIV cycles and fires the one-cycle refresh strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (slot_end) begin
            cnt <= '0;
            ce  <= 1'b1;
        end else begin
            cnt <= cnt + CNT_W'(1);
            ce  <= 1'b0;
        end
    end

    // Anode and pattern for the slot about to be loaded; uses the pre-update gear_q
    always_comb begin
        an_nxt   = 4'b1111;
        char_nxt = SEG_BLANK;
        case (idx)
            2'd0: an_nxt = 4'b0111;
            2'd1: begin
                an_nxt = 4'b1011;
                if (gear_q == 2'b01) char_nxt = SEG_D;
            end
            2'd2: begin
                an_nxt = 4'b1101;
                if (gear_q == 2'b10) char_nxt = SEG_N;
            end
            default: begin
                an_nxt = 4'b1110;
                if (gear_q == 2'b11) char_nxt = SEG_R;
            end
        endcase
    end

    // Slot registers rotate only on refresh edges so they are valid while ce is high
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= 2'd0;
            an_sel   <= 4'b1111;
            char_sel <= SEG_BLANK;
        end else if (slot_end) begin
            idx      <= idx + 2'd1;
            an_sel   <= an_nxt;
            char_sel <= char_nxt;
        end
    end

    // Filter next state: restart on a new value, otherwise saturate at STABLE_TICKS
    always_comb begin
        cand_nxt = cand;
        stb_nxt  = stb_cnt;
        if (gear_s != cand) begin
            cand_nxt = gear_s;
            stb_nxt  = STB_ONE;
        end else if (stb_cnt != STB_MAX) begin
            stb_nxt = stb_cnt + STB_ONE;
        end
        accept = (stb_nxt == STB_MAX);
    end

    // Gear filter sampled once per refresh strobe; gear_q follows a stable candidate
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand    <= 2'b00;
            stb_cnt <= '0;
            gear_q  <= 2'b00;
        end else if (slot_end) begin
            cand    <= cand_nxt;
            stb_cnt <= stb_nxt;
            if (accept) gear_q <= cand_nxt;
        end
    end

endmodule
